pc_redirect_unit: RTL and testbench

- Program-counter owner for the RV32IM core; consumes the branch-taken decision from the branch control unit (`branch_taken` plus the EX-stage target) and produces the fetch PC.
- Sequences pipeline redirection: updates PC, then drives a counted flush window into the IF/ID and ID/EX pipeline registers.
- Handles stall hold and a sticky halt for ECALL/EBREAK.

---
 rtl/pc_redirect_unit_pkg.sv | 15 +
 rtl/pc_redirect_unit_flush_counter.sv | 28 ++
 rtl/pc_redirect_unit.sv | 129 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit: state encodings, default vectors and counter width.
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        PCR_RUN   = 2'd0,
        PCR_FLUSH = 2'd1,
        PCR_HALT  = 2'd2,
        PCR_TRAP  = 2'd3
    } pcr_state_t;

    localparam logic [31:0] PCR_DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PCR_DEF_TRAP_VEC = 32'h0000_0004;
    localparam int          PCR_CNT_W        = 3;

endpackage

// File: rtl/pc_redirect_unit_flush_counter.sv
// Loadable down-counter that times the flush window after a redirect or trap entry.
module pc_redirect_unit_flush_counter
    import pc_redirect_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [PCR_CNT_W-1:0] load_val,
    input  logic                 dec,
    output logic                 last
);

    logic [PCR_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - PCR_CNT_W'(1);
        end
    end

    // Terminal flag: the current cycle is the final one of the window.
    assign last = (count == PCR_CNT_W'(1));

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: redirect, counted flush window, stall hold and sticky halt.
// Optional misaligned-target trap path is built when PC_MISALIGN_TRAP_EN is defined.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(PCR_DEF_RESET_PC),
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(PCR_DEF_TRAP_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            stall,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            flush_if,
    output logic            flush_id,
    output logic            redirect_busy,
    output logic            halted,
    output logic            misalign
);

    localparam logic [PCR_CNT_W-1:0] FLUSH_LD = PCR_CNT_W'(FLUSH_CYCLES);

    pcr_state_t      state, state_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] eff_target;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_last;
    logic            misalign_n;

    assign pc_plus4   = pc + XLEN'(4);
    assign eff_target = br_target & ~XLEN'(1);

    pc_redirect_unit_flush_counter u_flush_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (FLUSH_LD),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        misalign_n = 1'b0;
        case (state)
            PCR_RUN: begin
                if (halt_req) begin
                    state_n = PCR_HALT;
                end else if (branch_taken) begin
                    // A redirect overrides stall: the target must land regardless.
                    cnt_load = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                    if (br_target[1]) begin
                        state_n    = PCR_TRAP;
                        pc_n       = TRAP_VEC;
                        misalign_n = 1'b1;
                    end else begin
                        state_n = PCR_FLUSH;
                        pc_n    = eff_target;
                    end
`else
                    state_n = PCR_FLUSH;
                    pc_n    = eff_target;
`endif
                end else if (!stall) begin
                    pc_n = pc_plus4;
                end
            end
            PCR_FLUSH, PCR_TRAP: begin
                // Events here come from squashed instructions and are dropped.
                cnt_dec = 1'b1;
                if (!stall) begin
                    pc_n = pc_plus4;
                end
                if (cnt_last) begin
                    state_n = PCR_RUN;
                end
            end
            PCR_HALT: begin
                state_n = PCR_HALT;
            end
            default: begin
                state_n = PCR_RUN;
                pc_n    = TRAP_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= PCR_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_n;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign flush_if      = (state == PCR_FLUSH) || (state == PCR_TRAP) || (state == PCR_HALT);
    assign flush_id      = flush_if;
    assign redirect_busy = (state == PCR_FLUSH) || (state == PCR_TRAP);
    assign halted        = (state == PCR_HALT);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: per-cycle expectations queued at drive time, checked after the edge.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [31:0] br_target;
    logic        stall;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush_if;
    logic        flush_id;
    logic        redirect_busy;
    logic        halted;
    logic        misalign;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fl;
        logic        busy;
        logic        halt;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    pc_redirect_unit dut (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .br_target     (br_target),
        .stall         (stall),
        .halt_req      (halt_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .redirect_busy (redirect_busy),
        .halted        (halted),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue what must be visible after the edge, then compare.
    task automatic step(input string name, input logic r, input logic bt, input logic [31:0] tgt,
                        input logic st, input logic hr, input logic [31:0] epc, input logic efl,
                        input logic ebusy, input logic ehalt, input logic emis);
        exp_t e;
        @(negedge clk);
        rst          = r;
        branch_taken = bt;
        br_target    = tgt;
        stall        = st;
        halt_req     = hr;
        e.name = name;
        e.pc   = epc;
        e.fl   = efl;
        e.busy = ebusy;
        e.halt = ehalt;
        e.mis  = emis;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.name, "_pc"}, pc, e.pc);
            check({e.name, "_pc_plus4"}, pc_plus4, e.pc + 32'd4);
            check({e.name, "_flush_if"}, 32'(flush_if), 32'(e.fl));
            check({e.name, "_flush_id"}, 32'(flush_id), 32'(e.fl));
            check({e.name, "_busy"}, 32'(redirect_busy), 32'(e.busy));
            check({e.name, "_halted"}, 32'(halted), 32'(e.halt));
            check({e.name, "_misalign"}, 32'(misalign), 32'(e.mis));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        branch_taken = 1'b0;
        br_target    = 32'h0;
        stall        = 1'b0;
        halt_req     = 1'b0;

        //    name        rst bt  target        st  hr  pc            fl  busy halt mis
        step("reset0",    0,  0,  32'h0,        0,  0,  32'h0,        0,  0,   0,   0);
        step("reset1",    0,  0,  32'h0,        0,  0,  32'h0,        0,  0,   0,   0);
        step("adv4",      1,  0,  32'h0,        0,  0,  32'h4,        0,  0,   0,   0);
        step("adv8",      1,  0,  32'h0,        0,  0,  32'h8,        0,  0,   0,   0);
        step("advC",      1,  0,  32'h0,        0,  0,  32'hC,        0,  0,   0,   0);
        step("adv10",     1,  0,  32'h0,        0,  0,  32'h10,       0,  0,   0,   0);

        // Taken branch under stall, odd target; second branch inside window is dropped.
        step("br_stall",  1,  1,  32'h41,       1,  0,  32'h40,       1,  1,   0,   0);
        step("br_ignore", 1,  1,  32'h80,       0,  0,  32'h44,       1,  1,   0,   0);
        step("post_fl0",  1,  0,  32'h0,        0,  0,  32'h48,       0,  0,   0,   0);
        step("post_fl1",  1,  0,  32'h0,        0,  0,  32'h4C,       0,  0,   0,   0);

        // Reach RUN at 0x20, then halt beats branch.
        step("to18",      1,  1,  32'h18,       0,  0,  32'h18,       1,  1,   0,   0);
        step("to1C",      1,  0,  32'h0,        0,  0,  32'h1C,       1,  1,   0,   0);
        step("to20",      1,  0,  32'h0,        0,  0,  32'h20,       0,  0,   0,   0);
        step("halt",      1,  1,  32'h80,       0,  1,  32'h20,       1,  0,   1,   0);
        step("halt_hold", 1,  0,  32'h0,        0,  0,  32'h20,       1,  0,   1,   0);
        step("halt_br",   1,  1,  32'h100,      0,  0,  32'h20,       1,  0,   1,   0);
        step("halt_rst",  0,  0,  32'h0,        0,  0,  32'h0,        0,  0,   0,   0);
        step("halt_rel",  1,  0,  32'h0,        0,  0,  32'h4,        0,  0,   0,   0);

        // Wrap-around with a 3-cycle stall at the top address.
        step("toF4",      1,  1,  32'hFFFF_FFF4, 0, 0,  32'hFFFF_FFF4, 1, 1,   0,   0);
        step("toF8",      1,  0,  32'h0,        0,  0,  32'hFFFF_FFF8, 1,  1,   0,   0);
        step("toFC",      1,  0,  32'h0,        0,  0,  32'hFFFF_FFFC, 0,  0,   0,   0);
        step("stall0",    1,  0,  32'h0,        1,  0,  32'hFFFF_FFFC, 0,  0,   0,   0);
        step("stall1",    1,  0,  32'h0,        1,  0,  32'hFFFF_FFFC, 0,  0,   0,   0);
        step("stall2",    1,  0,  32'h0,        1,  0,  32'hFFFF_FFFC, 0,  0,   0,   0);
        step("wrap",      1,  0,  32'h0,        0,  0,  32'h0,        0,  0,   0,   0);
        step("wrap4",     1,  0,  32'h0,        0,  0,  32'h4,        0,  0,   0,   0);

        // Target with bit 1 set.
`ifdef PC_MISALIGN_TRAP_EN
        step("mis_br",    1,  1,  32'h102,      0,  0,  32'h4,        1,  1,   0,   1);
        step("mis_fl",    1,  0,  32'h0,        0,  0,  32'h8,        1,  1,   0,   0);
        step("mis_run",   1,  0,  32'h0,        0,  0,  32'hC,        0,  0,   0,   0);
`else
        step("mis_br",    1,  1,  32'h102,      0,  0,  32'h102,      1,  1,   0,   0);
        step("mis_fl",    1,  0,  32'h0,        0,  0,  32'h106,      1,  1,   0,   0);
        step("mis_run",   1,  0,  32'h0,        0,  0,  32'h10A,      0,  0,   0,   0);
`endif

        // Reset in the middle of a flush window aborts it.
        step("fl_br",     1,  1,  32'h200,      0,  0,  32'h200,      1,  1,   0,   0);
        step("fl_rst",    0,  0,  32'h0,        0,  0,  32'h0,        0,  0,   0,   0);
        step("fl_rel",    1,  0,  32'h0,        0,  0,  32'h4,        0,  0,   0,   0);

        if (exp_q.size() != 0) begin
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
